// File: rtl/pc_pkg.sv
// Shared definitions for the PC fetch controller.
// State encodings and the redirect bubble counter width.
package pc_pkg;

  typedef enum logic [1:0] {
    S_BOOT     = 2'd0,
    S_FETCH    = 2'd1,
    S_STALL    = 2'd2,
    S_REDIRECT = 2'd3
  } pc_state_t;

  localparam int BUB_W = 4;

endpackage

// File: rtl/pc_stall_counter.sv
// Saturating 32-bit cycle counter for stall/redirect cycles.
// Only instantiated when PC_STALL_COUNT_EN is defined.
module pc_stall_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  output logic [31:0] o_count
);

  logic [31:0] r_count;

  // count enabled cycles, hold at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_en && (r_count != 32'hFFFF_FFFF)) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC register and fetch sequencer: stalls, redirects, imem handshake.
// Optional macro PC_STALL_COUNT_EN adds the stall_cycles counter output.
module pc_fetch_ctrl
  import pc_pkg::*;
#(
  parameter int                 ADDR_W           = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC         = '0,
  parameter int                 REDIRECT_BUBBLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] PCNow,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] PCOut,
  output logic              imem_req,
  output logic              fetch_valid,
  output logic [ADDR_W-1:0] fetch_pc,
  output logic [1:0]        fsm_state
`ifdef PC_STALL_COUNT_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  localparam logic [BUB_W-1:0] BUBS = BUB_W'(REDIRECT_BUBBLES);

  pc_state_t        r_state;
  logic [BUB_W-1:0] r_bub;
  logic             w_accept;
  logic             w_branch;

  // request only in FETCH when neither stall nor redirect wins
  always_comb begin
    imem_req = (r_state == S_FETCH) & ~stall & ~branch_taken;
  end

  assign w_accept  = imem_req & imem_ready;
  assign w_branch  = branch_taken & (r_state != S_BOOT);
  assign fsm_state = r_state;

  // sequencer: redirect beats stall beats accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_BOOT;
      r_bub       <= '0;
      PCOut       <= RESET_PC;
      fetch_pc    <= RESET_PC;
      fetch_valid <= 1'b0;
    end else begin
      fetch_valid <= 1'b0;
      if (w_branch) begin
        PCOut   <= branch_target;
        r_bub   <= BUBS;
        r_state <= S_REDIRECT;
      end else begin
        unique case (r_state)
          S_BOOT: begin
            r_state <= S_FETCH;
          end
          S_FETCH: begin
            if (stall) begin
              r_state <= S_STALL;
            end else if (w_accept) begin
              fetch_pc    <= PCOut;
              PCOut       <= PCNow;
              fetch_valid <= 1'b1;
            end
          end
          S_STALL: begin
            if (!stall) r_state <= S_FETCH;
          end
          S_REDIRECT: begin
            if (r_bub <= 4'd1) begin
              r_bub   <= '0;
              r_state <= S_FETCH;
            end else begin
              r_bub <= r_bub - 1'b1;
            end
          end
          default: r_state <= S_BOOT;
        endcase
      end
    end
  end

`ifdef PC_STALL_COUNT_EN
  logic w_cnt_en;
  assign w_cnt_en = (r_state == S_STALL) | (r_state == S_REDIRECT);

  pc_stall_counter u_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_cnt_en),
    .o_count (stall_cycles)
  );
`endif

endmodule
